// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: boot sequencing, stall/back-pressure,
// branch redirect with a one-deep pending slot, and exception flush.
module pc_gen #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int          INST_BYTES = 4,
    parameter bit          ALIGN_CHK  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              if_ready,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign,
    output logic              pend_valid
);

    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              misalign_q, misalign_d;

    logic              accept;
    logic              load;
    logic [ADDR_W-1:0] load_target;

    assign accept = if_ready & ~stall;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ce_d          = ce_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = 1'b0;
        load          = 1'b0;
        load_target   = '0;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_BOOT;
                ce_d    = 1'b0;
                pc_d    = RST_PC;
            end
            ST_BOOT: begin
                state_d = ST_RUN;
                ce_d    = 1'b1;
            end
            ST_RUN: begin
                ce_d = 1'b1;
                if (flush) begin
                    load         = 1'b1;
                    load_target  = flush_pc;
                    pend_valid_d = 1'b0;
                end else if (branch_flag && accept) begin
                    load         = 1'b1;
                    load_target  = branch_target;
                    pend_valid_d = 1'b0;
                end else if (branch_flag) begin
                    // Fetch is blocked: park the redirect; a newer branch overwrites it.
                    pend_target_d = branch_target;
                    pend_valid_d  = 1'b1;
                end else if (pend_valid_q && accept) begin
                    load         = 1'b1;
                    load_target  = pend_target_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    pc_d = pc_q + STEP;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (load) begin
            pc_d       = load_target & ALIGN_MASK;
            misalign_d = ALIGN_CHK && (|(load_target & ~ALIGN_MASK));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RESET;
            pc_q         <= RST_PC;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
        end
        // NOTE: pend_target is pure data qualified by pend_valid, so it carries no reset.
        pend_target_q <= pend_target_d;
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign misalign   = misalign_q;
    assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, if_ready, branch_flag, flush;
    logic [31:0] branch_target, flush_pc;
    logic [31:0] pc;
    logic        ce, misalign, pend_valid;

    logic        rst16;
    logic [15:0] pc16;
    logic        ce16, misalign16, pend_valid16;

    int n_vec = 0;
    int n_err = 0;

    pc_gen u_dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .flush_pc(flush_pc),
        .pc(pc), .ce(ce), .misalign(misalign), .pend_valid(pend_valid)
    );

    pc_gen #(.ADDR_W(16), .RESET_VEC(32'h0000_BFC0), .INST_BYTES(2)) u_dut16 (
        .clk(clk), .rst(rst16), .stall(1'b0), .if_ready(1'b1),
        .branch_flag(1'b0), .branch_target(16'h0000),
        .flush(1'b0), .flush_pc(16'h0000),
        .pc(pc16), .ce(ce16), .misalign(misalign16), .pend_valid(pend_valid16)
    );

    // Reference model: cycles since reset release, and the architectural view of fetch.
    int          m_since_rst;
    logic [31:0] m_pc, m_ptgt;
    logic        m_ce, m_pend, m_mis;

    function automatic void m_load(input logic [31:0] x);
        m_pc  = (x / 32'd4) * 32'd4;
        m_mis = (x % 32'd4) != 0;
    endfunction

    function automatic void model_step();
        bit acc;
        acc = if_ready && !stall;
        if (rst) begin
            m_since_rst = 0; m_pc = 32'h0; m_ce = 0; m_pend = 0; m_mis = 0;
        end else if (m_since_rst < 2) begin
            m_since_rst++;
            m_mis = 0;
            if (m_since_rst == 2) m_ce = 1;
        end else begin
            m_mis = 0;
            if (flush) begin
                m_load(flush_pc); m_pend = 0;
            end else if (branch_flag && acc) begin
                m_load(branch_target); m_pend = 0;
            end else if (branch_flag) begin
                m_ptgt = branch_target; m_pend = 1;
            end else if (m_pend && acc) begin
                m_load(m_ptgt); m_pend = 0;
            end else if (acc) begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; if_ready = 1; branch_flag = 0; flush = 0;
        branch_target = 32'h0; flush_pc = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        n_vec++;
        if ({ce, pc, pend_valid, misalign} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_state ce=%b pc=%h pend=%b mis=%b exp ce=0 pc=0 pend=0 mis=0",
                              ce, pc, pend_valid, misalign);
        end
        rst = 0;
        tick();
        n_vec++;
        if (ce !== 1'b0 || pc !== 32'h0) begin
            n_err++; $display("FAIL boot_hold ce=%b pc=%h exp ce=0 pc=0", ce, pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (ce !== 1'b1 || pc !== exp_pc[i]) begin
                n_err++; $display("FAIL boot_seq[%0d] ce=%b pc=%h exp ce=1 pc=%h", i, ce, pc, exp_pc[i]);
            end
        end
        tick();  // pc = 0x10
    endtask

    task automatic test_stall();
        n_vec++;
        if (pc !== 32'h10) begin
            n_err++; $display("FAIL stall_start pc=%h exp=00000010", pc);
        end
        for (int i = 0; i < 5; i++) begin
            stall    = (i < 3);
            if_ready = (i >= 3) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (pc !== 32'h10 || ce !== 1'b1) begin
                n_err++; $display("FAIL stall_hold[%0d] pc=%h ce=%b exp pc=00000010 ce=1", i, pc, ce);
            end
        end
        idle_inputs();
        tick();
        n_vec++;
        if (pc !== 32'h14) begin
            n_err++; $display("FAIL stall_release pc=%h exp=00000014", pc);
        end
        repeat (3) tick();  // pc = 0x20
    endtask

    task automatic test_pending_branch();
        if_ready = 0; branch_flag = 1; branch_target = 32'h100;
        tick();
        branch_flag = 0;
        n_vec++;
        if (pend_valid !== 1'b1 || pc !== 32'h20) begin
            n_err++; $display("FAIL pend_capture pend=%b pc=%h exp pend=1 pc=00000020", pend_valid, pc);
        end
        tick();
        n_vec++;
        if (pend_valid !== 1'b1 || pc !== 32'h20) begin
            n_err++; $display("FAIL pend_hold pend=%b pc=%h exp pend=1 pc=00000020", pend_valid, pc);
        end
        if_ready = 1;
        tick();
        n_vec++;
        if (pend_valid !== 1'b0 || pc !== 32'h100) begin
            n_err++; $display("FAIL pend_load pend=%b pc=%h exp pend=0 pc=00000100", pend_valid, pc);
        end
        tick();
        n_vec++;
        if (pc !== 32'h104) begin
            n_err++; $display("FAIL pend_after pc=%h exp=00000104", pc);
        end
    endtask

    task automatic test_priority();
        // Park a redirect first so the flush also has to clear it.
        if_ready = 0; branch_flag = 1; branch_target = 32'h300;
        tick();
        if_ready = 1; stall = 1;
        flush = 1; flush_pc = 32'h8000_0180; branch_target = 32'h400;
        tick();
        n_vec++;
        if (pc !== 32'h8000_0180 || pend_valid !== 1'b0) begin
            n_err++; $display("FAIL prio_flush pc=%h pend=%b exp pc=80000180 pend=0", pc, pend_valid);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (pc !== 32'h8000_0184) begin
            n_err++; $display("FAIL prio_after pc=%h exp=80000184", pc);
        end
    endtask

    task automatic test_misalign_wrap();
        branch_flag = 1; branch_target = 32'h203;
        tick();
        branch_flag = 0;
        n_vec++;
        if (pc !== 32'h200 || misalign !== 1'b1) begin
            n_err++; $display("FAIL mis_branch pc=%h mis=%b exp pc=00000200 mis=1", pc, misalign);
        end
        tick();
        n_vec++;
        if (pc !== 32'h204 || misalign !== 1'b0) begin
            n_err++; $display("FAIL mis_pulse pc=%h mis=%b exp pc=00000204 mis=0", pc, misalign);
        end
        // Misaligned pending capture must not flag until it is loaded.
        if_ready = 0; branch_flag = 1; branch_target = 32'h501;
        tick();
        branch_flag = 0;
        n_vec++;
        if (misalign !== 1'b0 || pend_valid !== 1'b1) begin
            n_err++; $display("FAIL mis_capture mis=%b pend=%b exp mis=0 pend=1", misalign, pend_valid);
        end
        if_ready = 1;
        tick();
        n_vec++;
        if (pc !== 32'h500 || misalign !== 1'b1) begin
            n_err++; $display("FAIL mis_pend_load pc=%h mis=%b exp pc=00000500 mis=1", pc, misalign);
        end
        flush = 1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 0;
        n_vec++;
        if (pc !== 32'hFFFF_FFFC || misalign !== 1'b0) begin
            n_err++; $display("FAIL wrap_flush pc=%h mis=%b exp pc=fffffffc mis=0", pc, misalign);
        end
        tick();
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++; $display("FAIL wrap pc=%h exp=00000000", pc);
        end
    endtask

    task automatic test_reset_mid();
        if_ready = 0; branch_flag = 1; branch_target = 32'h700;
        tick();
        branch_flag = 0;
        rst = 1; flush = 1; flush_pc = 32'h1234;
        tick();
        n_vec++;
        if ({pend_valid, ce, pc, misalign} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid pend=%b ce=%b pc=%h mis=%b exp pend=0 ce=0 pc=0 mis=0",
                              pend_valid, ce, pc, misalign);
        end
        rst = 0;
        tick();
        n_vec++;
        if (ce !== 1'b0 || pc !== 32'h0) begin
            n_err++; $display("FAIL reset_mid_boot ce=%b pc=%h exp ce=0 pc=0 (inputs ignored)", ce, pc);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (ce !== 1'b1 || pc !== 32'h0) begin
            n_err++; $display("FAIL reset_mid_run ce=%b pc=%h exp ce=1 pc=0", ce, pc);
        end
    endtask

    task automatic test_param16();
        logic [15:0] exp16 [3] = '{16'hBFC0, 16'hBFC2, 16'hBFC4};
        rst16 = 1;
        tick();
        rst16 = 0;
        n_vec++;
        if (ce16 !== 1'b0 || pc16 !== 16'hBFC0) begin
            n_err++; $display("FAIL p16_reset ce=%b pc=%h exp ce=0 pc=bfc0", ce16, pc16);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (ce16 !== 1'b1 || pc16 !== exp16[i]) begin
                n_err++; $display("FAIL p16_seq[%0d] ce=%b pc=%h exp ce=1 pc=%h", i, ce16, pc16, exp16[i]);
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0:       a = $urandom() & 32'hFFFF_FFFC;
            1:       a = $urandom();
            2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: a = 32'($urandom_range(0, 255));
        endcase
        return a;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            if_ready      = ($urandom_range(0, 3) != 0);
            branch_flag   = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            branch_target = rand_addr();
            flush_pc      = rand_addr();
            tick();
            n_vec++;
            if ({ce, pc, pend_valid, misalign} !== {m_ce, m_pc, m_pend, m_mis}) begin
                n_err++;
                $display("FAIL rand[%0d] ce=%b pc=%h pend=%b mis=%b exp ce=%b pc=%h pend=%b mis=%b",
                         i, ce, pc, pend_valid, misalign, m_ce, m_pc, m_pend, m_mis);
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_since_rst = 0; m_pc = 32'h0; m_ptgt = 32'h0; m_ce = 0; m_pend = 0; m_mis = 0;
        rst   = 1;
        rst16 = 1;
        idle_inputs();
        test_reset();
        test_stall();
        test_pending_branch();
        test_priority();
        test_misalign_wrap();
        test_reset_mid();
        test_param16();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
